// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan path.
// Glyph bits are active-high {g,f,e,d,c,b,a}; panel polarity is applied later.
package seg_pkg;

  typedef logic [6:0] glyph_t;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_e;

  localparam glyph_t SEG_OFF = 7'h00;

  // Hex glyphs 0-9, A, b, C, d, E, F
  localparam glyph_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to hex-glyph decoder (active-high segments).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output glyph_t     glyph_o
);

  assign glyph_o = SEG_HEX[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: dwell/blank slot timing, per-digit
// enable/DP/blink masks, leading-zero blanking and frame-coherent input snapshots.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 64,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  input  logic                    blink_phase_i,
  input  logic                    lzb_en_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int DWELL_CYC = CLK_HZ / SCAN_HZ;
  localparam int CNT_W     = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int IDX_W     = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  localparam logic                  POL      = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{POL}};
  localparam logic [7:0]            SEG_IDLE = {8{POL}};

  if (DWELL_CYC <= BLANK_CYC) begin : g_bad_dwell
    $error("seg_scan_ctrl: DWELL_CYC must be greater than BLANK_CYC");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be in 2..16");
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_en_q, snap_blink_q;
  logic                    snap_phase_q, snap_lzb_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_q;

  logic                    snap_now_s;
  slot_e                   slot_s;
  logic [3:0]              nib_s;
  glyph_t                  glyph_s;
  logic [NUM_DIGITS-1:0]   nz_s, lz_s;
  logic                    dark_s;

  assign snap_now_s = (idx_q == '0) && (cnt_q == '0);
  assign slot_s     = (cnt_q >= CNT_BLANK) ? SLOT_SHOW : SLOT_BLANK;
  assign nib_s      = snap_digits_q[{idx_q, 2'b00} +: 4];

  seg_hex_decode u_hex (
    .nib_i   (nib_s),
    .glyph_o (glyph_s)
  );

  // Dwell counter and digit index advance
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Leading-zero map: digit k is LZ-blankable when nothing at or above it is nonzero or has a DP
  always_comb begin
    nz_s = '0;
    lz_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nz_s[k] = (snap_digits_q[4*k +: 4] != 4'h0) || snap_dp_q[k];
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lz_s[k] = ((nz_s >> k) == '0);
    end
  end

  assign dark_s = !snap_en_q[idx_q]
               || (snap_blink_q[idx_q] && snap_phase_q)
               || (snap_lzb_q && lz_s[idx_q] && (idx_q != '0));

  // Active-high next values for anodes and segments
  always_comb begin
    an_d  = '0;
    seg_d = {1'b0, SEG_OFF};
    case (slot_s)
      SLOT_SHOW: begin
        if (!dark_s) begin
          an_d  = NUM_DIGITS'(1) << idx_q;
          seg_d = {snap_dp_q[idx_q], glyph_s};
        end else begin
          an_d  = '0;
          seg_d = {1'b0, SEG_OFF};
        end
      end
      SLOT_BLANK: begin
        an_d  = '0;
        seg_d = {1'b0, SEG_OFF};
      end
      default: begin
        an_d  = '0;
        seg_d = {1'b0, SEG_OFF};
      end
    endcase
  end

  // Slot timing, frame snapshot and polarity-corrected output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      snap_blink_q  <= '0;
      snap_phase_q  <= 1'b0;
      snap_lzb_q    <= 1'b0;
      an_q          <= AN_IDLE;
      seg_q         <= SEG_IDLE;
      frame_q       <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= snap_now_s;
      if (snap_now_s) begin
        snap_digits_q <= digits_i;
        snap_dp_q     <= dp_i;
        snap_en_q     <= en_i;
        snap_blink_q  <= blink_mask_i;
        snap_phase_q  <= blink_phase_i;
        snap_lzb_q    <= lzb_en_i;
      end
      an_q  <= an_d ^ AN_IDLE;
      seg_q <= seg_d ^ SEG_IDLE;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 10-cycle dwell, 2-cycle blank, active-low.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [3:0]  en_i;
  logic [3:0]  blink_mask_i;
  logic        blink_phase_i;
  logic        lzb_en_i;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .CLK_HZ     (1000),
    .SCAN_HZ    (100),
    .BLANK_CYC  (2),
    .ACTIVE_LOW (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digits_i      (digits_i),
    .dp_i          (dp_i),
    .en_i          (en_i),
    .blink_mask_i  (blink_mask_i),
    .blink_phase_i (blink_phase_i),
    .lzb_en_i      (lzb_en_i),
    .seg_o         (seg_o),
    .an_o          (an_o),
    .frame_o       (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Wait for the next frame_o pulse (sampled on negedges); gap = negedges taken.
  task automatic sync_frame(input string tag, input int want_gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_o && n < 200);
    check(tag, n, want_gap);
  endtask

  // Check one full frame starting at the sample right after the snapshot edge.
  // exp_an/exp_seg pack per-slot values (slot 0 in the low bits).
  task automatic check_frame(input string tag, input logic [15:0] exp_an,
                             input logic [31:0] exp_seg, input int chg_k,
                             input logic [15:0] chg_val);
    int slot;
    int c;
    logic [12:0] want;
    for (int k = 0; k < 40; k++) begin
      if (k != 0) @(negedge clk);
      if (k == chg_k) digits_i = chg_val;
      slot = k / 10;
      c    = k % 10;
      if (c < 2) want = {4'hF, 8'hFF, (k == 0)};
      else       want = {exp_an[slot*4 +: 4], exp_seg[slot*8 +: 8], 1'b0};
      check($sformatf("%s k=%0d", tag, k), {19'h0, an_o, seg_o, frame_o}, {19'h0, want});
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    digits_i      = 16'h12AF;
    dp_i          = 4'b0100;
    en_i          = 4'b1111;
    blink_mask_i  = 4'b0000;
    blink_phase_i = 1'b0;
    lzb_en_i      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_an", {28'h0, an_o}, 32'h0000_000F);
    check("rst_seg", {24'h0, seg_o}, 32'h0000_00FF);
    check("rst_frame", {31'h0, frame_o}, 32'h0);

    // Release; slot shows F, A, 2 (with DP), 1
    rst_n = 1'b1;
    @(negedge clk);
    check_frame("scan", 16'h7BDE, 32'hF9_24_88_8E, -1, 16'h0);
    sync_frame("period", 1);

    // Leading-zero blanking
    lzb_en_i = 1'b1;
    digits_i = 16'h0005;
    dp_i     = 4'b0000;
    sync_frame("lzb5_sync", 40);
    check_frame("lzb5", 16'hFFFE, 32'hFF_FF_FF_92, -1, 16'h0);

    digits_i = 16'h0000;
    sync_frame("lzb0_sync", 1);
    check_frame("lzb0", 16'hFFFE, 32'hFF_FF_FF_C0, -1, 16'h0);

    dp_i = 4'b0100;
    sync_frame("lzbdp_sync", 1);
    check_frame("lzbdp", 16'hFBDE, 32'hFF_40_C0_C0, -1, 16'h0);

    // Blink off-phase darkens digits 2 and 3
    lzb_en_i      = 1'b0;
    dp_i          = 4'b0000;
    digits_i      = 16'h12AF;
    blink_mask_i  = 4'b1100;
    blink_phase_i = 1'b1;
    sync_frame("blink1_sync", 1);
    check_frame("blink1", 16'hFFDE, 32'hFF_FF_88_8E, -1, 16'h0);

    blink_phase_i = 1'b0;
    sync_frame("blink0_sync", 1);
    check_frame("blink0", 16'h7BDE, 32'hF9_A4_88_8E, -1, 16'h0);

    // Mid-frame input change must not tear the current frame
    sync_frame("coh_sync", 1);
    check_frame("coh_old", 16'h7BDE, 32'hF9_A4_88_8E, 15, 16'h3456);
    sync_frame("coh_sync2", 1);
    check_frame("coh_new", 16'h7BDE, 32'hB0_99_92_82, -1, 16'h0);

    // Reset during SHOW of slot 2
    sync_frame("mrst_sync", 1);
    repeat (25) @(negedge clk);
    check("mrst_pre", {20'h0, an_o, seg_o}, {20'h0, 4'b1011, 8'h99});
    #1 rst_n = 1'b0;
    #1;
    check("mrst_now", {19'h0, an_o, seg_o, frame_o}, {19'h0, 4'hF, 8'hFF, 1'b0});
    repeat (2) @(negedge clk);
    check("mrst_hold", {20'h0, an_o, seg_o}, {20'h0, 4'hF, 8'hFF});
    rst_n = 1'b1;
    @(negedge clk);
    check_frame("restart", 16'h7BDE, 32'hB0_99_92_82, -1, 16'h0);
    sync_frame("period2", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
